// File: rtl/eth_pkt_lpbk.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkt_lpbk
// Purpose  : Store-and-forward Ethernet loopback responder, 256-bit Avalon-ST.
//            Buffers each complete RX frame. The MAC addresses can optionally
//            be swapped on the first beat. Each frame is then sent on TX.
//            Errored, runt (<12 B) and oversize frames are dropped whole,
//            because a frame only becomes visible to the reader once its eop
//            beat has been committed.
// Ports    : clk_i, reset_n_i       - clock, async active-low reset
//            cfg_swap_en_i         - swap dst/src MAC on the first TX beat
//            stat_clr_i            - synchronous clear of the stat counters
//            rx_*_i / rx_ready_o   - Avalon-ST sink, readyLatency 0
//            tx_*_o / tx_ready_i   - Avalon-ST source, readyLatency 0
//            stat_*_pkt_o          - wrapping 32-bit frame counters
// Revision : 1.0 - initial release
// ============================================================================
module eth_pkt_lpbk #(
  parameter int DEPTH     = 64,
  parameter int MAX_BEATS = 48
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         cfg_swap_en_i,
  input  logic         stat_clr_i,
  input  logic [255:0] rx_data_i,
  input  logic         rx_valid_i,
  input  logic         rx_sop_i,
  input  logic         rx_eop_i,
  input  logic [4:0]   rx_empty_i,
  input  logic [5:0]   rx_error_i,
  output logic         rx_ready_o,
  input  logic         tx_ready_i,
  output logic [255:0] tx_data_o,
  output logic         tx_valid_o,
  output logic         tx_sop_o,
  output logic         tx_eop_o,
  output logic [4:0]   tx_empty_o,
  output logic         tx_error_o,
  output logic [31:0]  stat_rx_pkt_o,
  output logic [31:0]  stat_tx_pkt_o,
  output logic [31:0]  stat_drop_pkt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_BEATS + 1) + 1;
  localparam int EW = 256 + 1 + 5;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_PKT  = 2'd1;
  localparam logic [1:0] W_DISC = 2'd2;

  localparam logic [4:0]    SHORT_EMPTY = 5'd20;
  localparam logic [PW-1:0] DEPTH_P     = PW'(DEPTH);
  localparam logic [CW-1:0] MAX_C       = CW'(MAX_BEATS);

  // Entry layout: {data[255:0], eop, empty[4:0]}
  logic [EW-1:0] mem_q [DEPTH];

  logic [1:0]    wst_q, wst_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          short_q, short_d;
  logic          disc_cnt_q, disc_cnt_d;
  logic          ready_en_q;

  logic          tx_valid_q, tx_sop_q, tx_eop_q, sop_next_q;
  logic [255:0]  tx_data_q;
  logic [4:0]    tx_empty_q;
  logic [31:0]   stat_rx_q, stat_tx_q, stat_drop_q;

  logic [PW-1:0] w_occ;
  logic          w_acc;
  logic          w_write;
  logic          mem_we;
  logic [PW-1:0] w_base;
  logic [1:0]    rx_inc, drop_inc;

  logic          w_load;
  logic [EW-1:0] w_rd_ent;
  logic [255:0]  w_tx_data;
  logic          w_tx_eop_xfer;

  // Occupancy counts speculative beats too, so an in-progress frame can
  // never overrun committed data that the reader has not drained yet.
  assign w_occ      = wr_ptr_q - rd_ptr_q;
  assign rx_ready_o = ready_en_q & ((wst_q == W_DISC) | (w_occ < DEPTH_P));
  assign w_acc      = rx_valid_i & rx_ready_o;

  // --------------------------------------------------------------------------
  // Write-side frame FSM
  // --------------------------------------------------------------------------
  always_comb begin
    wst_d       = wst_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    short_d     = short_q;
    disc_cnt_d  = disc_cnt_q;
    w_write     = 1'b0;
    w_base      = wr_ptr_q;
    rx_inc      = 2'd0;
    drop_inc    = 2'd0;

    if (w_acc) begin
      if (rx_eop_i) rx_inc = rx_inc + 2'd1;
      case (wst_q)
        W_IDLE: begin
          if (rx_sop_i) begin
            w_write = 1'b1;
            cnt_d   = CW'(1);
            err_d   = |rx_error_i;
            short_d = (rx_empty_i > SHORT_EMPTY);
          end else begin
            // Orphan beat: nothing was counted for it yet.
            wst_d      = W_DISC;
            disc_cnt_d = 1'b1;
          end
        end
        W_PKT: begin
          if (rx_sop_i) begin
            // Abort the partial frame and restart at the last commit point.
            rx_inc   = rx_inc + 2'd1;
            drop_inc = drop_inc + 2'd1;
            w_write  = 1'b1;
            w_base   = wr_commit_q;
            cnt_d    = CW'(1);
            err_d    = |rx_error_i;
            short_d  = (rx_empty_i > SHORT_EMPTY);
          end else if (cnt_q >= MAX_C) begin
            // Oversize: the drop is counted here, so the discard of the
            // remaining beats must not count it again.
            drop_inc   = drop_inc + 2'd1;
            wr_ptr_d   = wr_commit_q;
            wst_d      = rx_eop_i ? W_IDLE : W_DISC;
            disc_cnt_d = 1'b0;
          end else begin
            w_write = 1'b1;
            cnt_d   = cnt_q + CW'(1);
            err_d   = err_q | (|rx_error_i);
          end
        end
        W_DISC: begin
          if (rx_eop_i) begin
            if (disc_cnt_q) drop_inc = drop_inc + 2'd1;
            disc_cnt_d = 1'b0;
            wst_d      = W_IDLE;
          end
        end
        default: wst_d = W_IDLE;
      endcase

      if (w_write) begin
        if (rx_eop_i) begin
          if (err_d | short_d) begin
            wr_ptr_d = wr_commit_q;
            drop_inc = drop_inc + 2'd1;
          end else begin
            wr_ptr_d    = w_base + PW'(1);
            wr_commit_d = w_base + PW'(1);
          end
          wst_d = W_IDLE;
        end else begin
          wr_ptr_d = w_base + PW'(1);
          wst_d    = W_PKT;
        end
      end
    end
  end

  assign mem_we = w_write;

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[w_base[AW-1:0]] <= {rx_data_i, rx_eop_i, rx_empty_i};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wst_q       <= W_IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      short_q     <= 1'b0;
      disc_cnt_q  <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      wst_q       <= wst_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      short_q     <= short_d;
      disc_cnt_q  <= disc_cnt_d;
      ready_en_q  <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Read side: one output register, refilled whenever it is empty or drains.
  // --------------------------------------------------------------------------
  assign w_rd_ent = mem_q[rd_ptr_q[AW-1:0]];
  assign w_load   = (rd_ptr_q != wr_commit_q) & (~tx_valid_q | tx_ready_i);

  always_comb begin
    w_tx_data = w_rd_ent[EW-1:6];
    if (cfg_swap_en_i & sop_next_q) begin
      w_tx_data = {w_rd_ent[EW-1-48:EW-96], w_rd_ent[EW-1:EW-48], w_rd_ent[EW-97:6]};
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_valid_q <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_empty_q <= '0;
      sop_next_q <= 1'b1;
      rd_ptr_q   <= '0;
    end else if (w_load) begin
      tx_valid_q <= 1'b1;
      tx_sop_q   <= sop_next_q;
      tx_eop_q   <= w_rd_ent[5];
      tx_data_q  <= w_tx_data;
      tx_empty_q <= w_rd_ent[5] ? w_rd_ent[4:0] : 5'd0;
      sop_next_q <= w_rd_ent[5];
      rd_ptr_q   <= rd_ptr_q + PW'(1);
    end else if (tx_ready_i & tx_valid_q) begin
      tx_valid_q <= 1'b0;
    end
  end

  assign w_tx_eop_xfer = tx_valid_q & tx_ready_i & tx_eop_q;

  // --------------------------------------------------------------------------
  // Statistics; clear wins over a same-cycle increment.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stat_rx_q   <= '0;
      stat_tx_q   <= '0;
      stat_drop_q <= '0;
    end else if (stat_clr_i) begin
      stat_rx_q   <= '0;
      stat_tx_q   <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_rx_q   <= stat_rx_q + {30'd0, rx_inc};
      stat_tx_q   <= stat_tx_q + {31'd0, w_tx_eop_xfer};
      stat_drop_q <= stat_drop_q + {30'd0, drop_inc};
    end
  end

  assign tx_data_o       = tx_data_q;
  assign tx_valid_o      = tx_valid_q;
  assign tx_sop_o        = tx_sop_q;
  assign tx_eop_o        = tx_eop_q;
  assign tx_empty_o      = tx_empty_q;
  assign tx_error_o      = 1'b0;
  assign stat_rx_pkt_o   = stat_rx_q;
  assign stat_tx_pkt_o   = stat_tx_q;
  assign stat_drop_pkt_o = stat_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_pkt_lpbk.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_pkt_lpbk
// Purpose  : Self-checking bench for eth_pkt_lpbk. A frame-level reference
//            model decides which frames survive and what they look like on TX.
//            A monitor compares every TX transfer against that model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_pkt_lpbk;
  localparam int DEPTH     = 64;
  localparam int MAX_BEATS = 48;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cfg_swap_en = 1'b0;
  logic         stat_clr = 1'b0;
  logic [255:0] rx_data = '0;
  logic         rx_valid = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0;
  logic [4:0]   rx_empty = '0;
  logic [5:0]   rx_error = '0;
  logic         rx_ready_o;
  logic         tx_ready_i = 1'b0;
  logic [255:0] tx_data_o;
  logic         tx_valid_o, tx_sop_o, tx_eop_o, tx_error_o;
  logic [4:0]   tx_empty_o;
  logic [31:0]  stat_rx_pkt_o, stat_tx_pkt_o, stat_drop_pkt_o;

  always #5 clk = ~clk;

  eth_pkt_lpbk #(.DEPTH(DEPTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .cfg_swap_en_i(cfg_swap_en), .stat_clr_i(stat_clr),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_sop_i(rx_sop), .rx_eop_i(rx_eop),
    .rx_empty_i(rx_empty), .rx_error_i(rx_error), .rx_ready_o(rx_ready_o),
    .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .tx_sop_o(tx_sop_o), .tx_eop_o(tx_eop_o), .tx_empty_o(tx_empty_o), .tx_error_o(tx_error_o),
    .stat_rx_pkt_o(stat_rx_pkt_o), .stat_tx_pkt_o(stat_tx_pkt_o), .stat_drop_pkt_o(stat_drop_pkt_o)
  );

  typedef struct {
    logic [255:0] data;
    logic         sop;
    logic         eop;
    logic [4:0]   empty;
  } beat_t;

  int    total = 0;
  int    bad   = 0;
  beat_t exp_q[$];
  beat_t cur_q[$];
  bit    in_frame = 0, discarding = 0, cur_err = 0;
  int    exp_rx = 0, exp_tx = 0, exp_drop = 0;
  int    tx_mode = 1;   // 0: random ready, 1: always ready, 2: never ready
  bit    mon_en = 0;
  bit    prev_valid = 0, prev_ready = 0;
  logic [255:0] prev_data = '0;
  beat_t mon_e;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Frame-level reference: a frame is a run of beats from sop to eop; it is
  // reflected only if it has at most MAX_BEATS beats, carries no error and is
  // at least 12 bytes long.
  task automatic model_beat(input beat_t b, input bit err, input bit swap);
    if (b.eop) exp_rx++;
    if (in_frame && b.sop) begin
      exp_drop++;
      exp_rx++;
      in_frame = 0;
    end
    if (!in_frame && !discarding) begin
      if (b.sop) begin
        in_frame = 1;
        cur_q.delete();
        cur_err = 0;
      end else begin
        discarding = 1;
      end
    end
    if (in_frame) begin
      cur_q.push_back(b);
      cur_err |= err;
    end
    if (b.eop) begin
      if (in_frame) begin
        if (cur_err || cur_q.size() > MAX_BEATS || cur_q[0].empty > 5'd20) begin
          exp_drop++;
        end else begin
          for (int i = 0; i < cur_q.size(); i++) begin
            beat_t e = cur_q[i];
            if (i == 0 && swap)
              e.data = {cur_q[i].data[207:160], cur_q[i].data[255:208], cur_q[i].data[159:0]};
            e.sop = (i == 0);
            e.eop = (i == cur_q.size() - 1);
            if (!e.eop) e.empty = 5'd0;
            exp_q.push_back(e);
          end
          exp_tx++;
        end
        in_frame = 0;
      end else if (discarding) begin
        exp_drop++;
        discarding = 0;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [255:0] d, input logic s, input logic e,
                           input logic [4:0] emp, input logic [5:0] er, inout int stalls);
    beat_t b;
    int guard = 0;
    rx_data = d; rx_sop = s; rx_eop = e; rx_empty = emp; rx_error = er; rx_valid = 1'b1;
    while (rx_ready_o !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
      stalls++;
    end
    if (guard >= 2000) begin
      total++;
      bad++;
      $error("FAIL rx_accept_timeout observed=stalled expected=accepted");
    end
    b.data = d; b.sop = s; b.eop = e; b.empty = emp;
    model_beat(b, |er, cfg_swap_en);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit do_eop, input logic [4:0] last_empty,
                            input int err_at, input bit use_hdr, input logic [95:0] hdr,
                            output int stalls);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      logic [255:0] d = rnd256();
      logic last = do_eop && (i == n - 1);
      if (use_hdr && i == 0) d[255:160] = hdr;
      send_beat(d, i == 0, last, last ? last_empty : 5'd0,
                (i == err_at) ? 6'h01 : 6'h00, stalls);
    end
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while (exp_q.size() != 0 && g < 20000) begin
      @(negedge clk);
      g++;
    end
    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL %s_drain observed=%0d beats left expected=0", tag, exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_stat_rx"},   256'(stat_rx_pkt_o),   256'(exp_rx));
    chk({tag, "_stat_tx"},   256'(stat_tx_pkt_o),   256'(exp_tx));
    chk({tag, "_stat_drop"}, 256'(stat_drop_pkt_o), 256'(exp_drop));
  endtask

  task automatic clear_stats();
    @(negedge clk) stat_clr = 1'b1;
    @(negedge clk) stat_clr = 1'b0;
    exp_rx = 0; exp_tx = 0; exp_drop = 0;
  endtask

  // TX monitor and ready driver.
  always @(negedge clk) begin
    if (tx_mode == 1)      tx_ready_i = 1'b1;
    else if (tx_mode == 2) tx_ready_i = 1'b0;
    else                   tx_ready_i = 1'($urandom_range(0, 1));
    if (mon_en) begin
      if (prev_valid && !prev_ready) begin
        chk("tx_hold_valid", 256'(tx_valid_o), 256'(1'b1));
        chk("tx_hold_data", tx_data_o, prev_data);
      end
      if (tx_valid_o && tx_ready_i) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL tx_unexpected_beat observed=%0h expected=none", tx_data_o);
        end
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("tx_data", tx_data_o, mon_e.data);
          chk("tx_sop", 256'(tx_sop_o), 256'(mon_e.sop));
          chk("tx_eop", 256'(tx_eop_o), 256'(mon_e.eop));
          chk("tx_empty", 256'(tx_empty_o), 256'(mon_e.empty));
          chk("tx_error", 256'(tx_error_o), 256'(1'b0));
        end
      end
      prev_valid = tx_valid_o;
      prev_ready = tx_ready_i;
      prev_data  = tx_data_o;
    end else begin
      prev_valid = 0;
    end
  end

  initial begin
    int st;
    logic [6:0] occ;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tx_valid", 256'(tx_valid_o), 256'(1'b0));
    chk("rst_tx_sop",   256'(tx_sop_o),   256'(1'b0));
    chk("rst_tx_eop",   256'(tx_eop_o),   256'(1'b0));
    chk("rst_tx_data",  tx_data_o,        256'(0));
    chk("rst_tx_empty", 256'(tx_empty_o), 256'(0));
    chk("rst_rx_ready", 256'(rx_ready_o), 256'(1'b0));
    chk("rst_stat_rx",  256'(stat_rx_pkt_o), 256'(0));
    reset_n = 1'b1;
    @(negedge clk);
    chk("rx_ready_after_release", 256'(rx_ready_o), 256'(1'b1));

    // 64 B frame with MAC swap, plus latency
    mon_en = 1; tx_mode = 1; cfg_swap_en = 1'b1;
    send_frame(2, 1, 5'd0, -1, 1, 96'h0011_2233_4455_6677_8899_AABB, st);
    chk("lat_n1_valid", 256'(tx_valid_o), 256'(1'b0));
    @(negedge clk);
    chk("lat_n2_valid", 256'(tx_valid_o), 256'(1'b1));
    chk("lat_n2_sop",   256'(tx_sop_o),   256'(1'b1));
    chk("swap_dst", 256'(tx_data_o[255:208]), 256'(48'h6677_8899_AABB));
    chk("swap_src", 256'(tx_data_o[207:160]), 256'(48'h0011_2233_4455));
    drain("t1");
    check_stats("t1");
    chk("t1_rx_is_1", 256'(stat_rx_pkt_o), 256'(1));
    clear_stats();
    chk("clr_stat_rx", 256'(stat_rx_pkt_o), 256'(0));
    chk("clr_stat_tx", 256'(stat_tx_pkt_o), 256'(0));

    // 10 back-to-back 1518 B frames, random TX backpressure
    cfg_swap_en = 1'b0; tx_mode = 0;
    for (int f = 0; f < 10; f++) send_frame(48, 1, 5'd18, -1, 0, 96'h0, st);
    drain("t2");
    check_stats("t2");
    occ = dut.wr_ptr_q - dut.rd_ptr_q;
    chk("t2_final_occ", 256'(occ), 256'(0));
    clear_stats();

    // Error on third beat, then a good frame
    cfg_swap_en = 1'b1;
    send_frame(4, 1, 5'd3, 2, 0, 96'h0, st);
    send_frame(3, 1, 5'd7, -1, 0, 96'h0, st);
    drain("t3");
    check_stats("t3");
    chk("t3_drop_is_1", 256'(stat_drop_pkt_o), 256'(1));
    clear_stats();

    // 50-beat oversize frame
    tx_mode = 1;
    send_frame(50, 1, 5'd0, -1, 0, 96'h0, st);
    chk("t4_no_rx_stall", 256'(st), 256'(0));
    repeat (6) @(negedge clk);
    drain("t4");
    check_stats("t4");
    clear_stats();

    // Partial frame aborted by a new sop, then a full 3-beat frame
    send_frame(2, 0, 5'd0, -1, 0, 96'h0, st);
    send_frame(3, 1, 5'd1, -1, 0, 96'h0, st);
    drain("t5");
    check_stats("t5");
    clear_stats();

    // 12-byte boundary: empty=20 kept, empty=21 dropped
    send_frame(1, 1, 5'd20, -1, 0, 96'h0, st);
    send_frame(1, 1, 5'd21, -1, 0, 96'h0, st);
    drain("t6");
    check_stats("t6");
    clear_stats();

    // Random frame mix
    cfg_swap_en = 1'($urandom_range(0, 1)); tx_mode = 0;
    for (int f = 0; f < 20; f++) begin
      int n = $urandom_range(1, MAX_BEATS);
      int ea = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
      send_frame(n, 1, 5'($urandom_range(0, 31)), ea, 0, 96'h0, st);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain("t7");
    check_stats("t7");

    // Reset while a frame is held on TX
    tx_mode = 2;
    send_frame(3, 1, 5'd0, -1, 0, 96'h0, st);
    repeat (4) @(negedge clk);
    chk("t8_held_valid", 256'(tx_valid_o), 256'(1'b1));
    mon_en = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("t8_async_valid", 256'(tx_valid_o), 256'(1'b0));
    chk("t8_stat_rx",     256'(stat_rx_pkt_o), 256'(0));
    chk("t8_stat_tx",     256'(stat_tx_pkt_o), 256'(0));
    chk("t8_stat_drop",   256'(stat_drop_pkt_o), 256'(0));
    exp_q.delete(); cur_q.delete();
    in_frame = 0; discarding = 0;
    exp_rx = 0; exp_tx = 0; exp_drop = 0;
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    chk("t8_rx_ready", 256'(rx_ready_o), 256'(1'b1));
    tx_mode = 1; mon_en = 1;
    repeat (10) @(negedge clk);
    chk("t8_no_stale_tx", 256'(tx_valid_o), 256'(1'b0));
    send_frame(2, 1, 5'd4, -1, 0, 96'h0, st);
    drain("t8");
    check_stats("t8");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
